// File: rtl/predicted_fetch_unit_pkg.sv
// Shared definitions for the predicted fetch front end: 2-bit counter
// encodings and the saturating counter update used by the BTB.
package predicted_fetch_unit_pkg;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WEAK_NT;
  localparam ctr_t CTR_ALLOC = CTR_WEAK_T;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t result;
    result = ctr;
    if (taken && ctr != CTR_STRONG_T)
      result = ctr_t'(ctr + 2'd1);
    else if (!taken && ctr != CTR_STRONG_NT)
      result = ctr_t'(ctr - 2'd1);
    return result;
  endfunction

endpackage

// File: rtl/predicted_fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// clock-edge update from the EX resolution bus, asynchronous clear.
module btb_table
  import predicted_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH    = 9,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-3:0] lookup_word,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_en,
  input  logic [PC_WIDTH-3:0] upd_word,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target
);

  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int WORD_W = PC_WIDTH - 2;
  localparam int TAG_W  = WORD_W - IDX_W;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
    ctr_t                ctr;
  } btb_entry_t;

  btb_entry_t entries [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_entry, up_entry;
  logic             lk_hit, up_hit;

  assign lk_idx      = lookup_word[IDX_W-1:0];
  assign lk_tag      = lookup_word[WORD_W-1:IDX_W];
  assign lk_entry    = entries[lk_idx];
  assign lk_hit      = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign pred_taken  = lk_hit && lk_entry.ctr[1];
  assign pred_target = lk_entry.target;

  assign up_idx   = upd_word[IDX_W-1:0];
  assign up_tag   = upd_word[WORD_W-1:IDX_W];
  assign up_entry = entries[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  // A taken miss evicts whatever occupies the slot; a not-taken miss is not worth a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++)
        entries[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
    end else if (upd_en) begin
      if (up_hit) begin
        entries[up_idx].ctr <= ctr_next(up_entry.ctr, upd_taken);
        if (upd_taken)
          entries[up_idx].target <= upd_target;
      end else if (upd_taken) begin
        entries[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_ALLOC};
      end
    end
  end

endmodule

// File: rtl/predicted_fetch_unit.sv
// Instruction-fetch front end: PC register, BTB-predicted next PC, IF/ID
// buffer tagged with the prediction, mispredict flush and perf counters.
module predicted_fetch_unit
  import predicted_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH          = 9,
  parameter int                  INSTRUCTION_WIDTH = 32,
  parameter int                  BTB_ENTRIES       = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0,
  parameter int                  CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  input  logic                         ex_valid,
  input  logic                         ex_is_branch,
  input  logic [PC_WIDTH-1:0]          ex_pc,
  input  logic                         ex_taken,
  input  logic [PC_WIDTH-1:0]          ex_target,
  input  logic                         ex_pred_taken,
  input  logic [PC_WIDTH-1:0]          ex_pred_target,
  output logic                         if_valid,
  output logic [PC_WIDTH-1:0]          if_pc,
  output logic [INSTRUCTION_WIDTH-1:0] if_instr,
  output logic                         if_pred_taken,
  output logic [PC_WIDTH-1:0]          if_pred_target,
  output logic                         flush,
  output logic [CNT_WIDTH-1:0]         branch_cnt,
  output logic [CNT_WIDTH-1:0]         mispred_cnt
);

  typedef struct packed {
    logic                valid;
    logic                is_branch;
    logic [PC_WIDTH-1:0] addr;
    logic                taken;
    logic [PC_WIDTH-1:0] target;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
  } branch_res_t;

  typedef struct packed {
    logic                         valid;
    logic [PC_WIDTH-1:0]          addr;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic                         pred_taken;
    logic [PC_WIDTH-1:0]          pred_target;
  } if_id_t;

  branch_res_t         res;
  if_id_t              if_id;
  logic [PC_WIDTH-1:0] pc, next_pc, redirect, lk_target;
  logic                lk_taken, upd_en, mispredict;

  assign res = '{valid: ex_valid, is_branch: ex_is_branch, addr: ex_pc, taken: ex_taken,
                 target: ex_target, pred_taken: ex_pred_taken, pred_target: ex_pred_target};

  btb_table #(
    .PC_WIDTH   (PC_WIDTH),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_word(pc[PC_WIDTH-1:2]),
    .pred_taken (lk_taken),
    .pred_target(lk_target),
    .upd_en     (upd_en),
    .upd_word   (res.addr[PC_WIDTH-1:2]),
    .upd_taken  (res.taken),
    .upd_target (res.target)
  );

  // Target only matters when the branch actually went; a not-taken branch is
  // correctly predicted whatever stale target it carried.
  assign upd_en     = res.valid && res.is_branch;
  assign mispredict = upd_en && ((res.taken != res.pred_taken) ||
                                 (res.taken && (res.target != res.pred_target)));
  assign flush      = mispredict;
  assign redirect   = res.taken ? res.target : res.addr + PC_WIDTH'(4);
  assign next_pc    = lk_taken ? lk_target : pc + PC_WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      if_id <= '0;
    end else if (flush) begin
      pc    <= redirect;
      if_id <= '0;
    end else if (!stall) begin
      pc    <= next_pc;
      if_id <= '{valid: 1'b1, addr: pc, instr: imem_data,
                 pred_taken: lk_taken, pred_target: lk_target};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_en)
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mispredict)
        mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

  assign imem_addr      = pc;
  assign if_valid       = if_id.valid;
  assign if_pc          = if_id.addr;
  assign if_instr       = if_id.instr;
  assign if_pred_taken  = if_id.pred_taken;
  assign if_pred_target = if_id.pred_target;

endmodule

// File: tb/tb_predicted_fetch_unit.sv
// Table-driven bench for predicted_fetch_unit with a 4-entry BTB; the bench
// plays the EX stage and scoreboards the post-edge fetch state.
module tb_predicted_fetch_unit;

  localparam int PW = 9;
  localparam int IW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [PW-1:0] ex_pc, ex_target, ex_pred_target;
  logic          if_valid, if_pred_taken, flush;
  logic [PW-1:0] if_pc, if_pred_target;
  logic [IW-1:0] if_instr;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  typedef struct {
    logic          st, ev, eb;
    logic [PW-1:0] epc;
    logic          et;
    logic [PW-1:0] etg;
    logic          ept;
    logic [PW-1:0] eptg;
    logic          fl;
    logic [PW-1:0] npc;
    logic          iv;
    logic [PW-1:0] ipc;
    logic          ipt;
    logic [PW-1:0] iptg;
    logic [CW-1:0] bc, mc;
  } vec_t;

  typedef struct {
    logic [PW-1:0] pc;
    logic          iv;
    logic [PW-1:0] ipc;
    logic [IW-1:0] instr;
    logic          ipt;
    logic [PW-1:0] iptg;
    logic [CW-1:0] bc, mc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] a);
    return 32'h1300_0000 | {23'd0, a};
  endfunction

  always #5 clk = ~clk;
  assign imem_data = instr_of(imem_addr);

  predicted_fetch_unit #(
    .PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .BTB_ENTRIES(4),
    .RESET_PC(9'h000), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  function automatic vec_t v(input logic st, ev, eb, input logic [PW-1:0] epc, input logic et,
                             input logic [PW-1:0] etg, input logic ept, input logic [PW-1:0] eptg,
                             input logic fl, input logic [PW-1:0] npc, input logic iv,
                             input logic [PW-1:0] ipc, input logic ipt, input logic [PW-1:0] iptg,
                             input int bc, input int mc);
    vec_t t;
    t.st = st; t.ev = ev; t.eb = eb; t.epc = epc; t.et = et; t.etg = etg;
    t.ept = ept; t.eptg = eptg; t.fl = fl; t.npc = npc; t.iv = iv; t.ipc = ipc;
    t.ipt = ipt; t.iptg = iptg; t.bc = CW'(bc); t.mc = CW'(mc);
    return t;
  endfunction

  // Plain advance with no branch on the resolution bus.
  function automatic vec_t adv(input logic [PW-1:0] npc, ipc, input logic ipt,
                               input logic [PW-1:0] iptg, input int bc, mc);
    return v(0, 0, 0, 9'h0, 0, 9'h0, 0, 9'h0, 0, npc, 1, ipc, ipt, iptg, bc, mc);
  endfunction

  // Mispredicting branch: flush, IF/ID cleared, pc to the redirect.
  function automatic vec_t mis(input logic st, input logic [PW-1:0] epc, input logic et,
                               input logic [PW-1:0] etg, input logic ept,
                               input logic [PW-1:0] eptg, npc, input int bc, mc);
    return v(st, 1, 1, epc, et, etg, ept, eptg, 1, npc, 0, 9'h0, 0, 9'h0, bc, mc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " pc"},          imem_addr,      e.pc);
      check({tag, " if_valid"},    if_valid,       e.iv);
      check({tag, " if_pc"},       if_pc,          e.ipc);
      check({tag, " if_instr"},    if_instr,       e.instr);
      check({tag, " pred_taken"},  if_pred_taken,  e.ipt);
      check({tag, " pred_target"}, if_pred_target, e.iptg);
      check({tag, " branch_cnt"},  branch_cnt,     e.bc);
      check({tag, " mispred_cnt"}, mispred_cnt,    e.mc);
    end
  endtask

  task automatic applyStimulus(input vec_t t, input string tag);
    exp_t e;
    stall = t.st; ex_valid = t.ev; ex_is_branch = t.eb; ex_pc = t.epc;
    ex_taken = t.et; ex_target = t.etg; ex_pred_taken = t.ept; ex_pred_target = t.eptg;
    #1;
    check({tag, " flush"}, flush, t.fl);
    e.pc = t.npc; e.iv = t.iv; e.ipc = t.ipc; e.instr = t.iv ? instr_of(t.ipc) : '0;
    e.ipt = t.ipt; e.iptg = t.iptg; e.bc = t.bc; e.mc = t.mc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkReset(input string tag);
    check({tag, " pc"},          imem_addr,      9'h000);
    check({tag, " if_valid"},    if_valid,       1'b0);
    check({tag, " if_pc"},       if_pc,          9'h000);
    check({tag, " if_instr"},    if_instr,       32'h0);
    check({tag, " pred_taken"},  if_pred_taken,  1'b0);
    check({tag, " pred_target"}, if_pred_target, 9'h000);
    check({tag, " branch_cnt"},  branch_cnt,     16'h0);
    check({tag, " mispred_cnt"}, mispred_cnt,    16'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0;
    ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;

    // Sequential fetch, loop branch 0x20->0x10, counter training/detraining,
    // stalls, aliasing in the 4-entry table, PC wrap and non-branch resolutions.
    vecs.push_back(adv(9'h004, 9'h000, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h008, 9'h004, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h00C, 9'h008, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h010, 9'h00C, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h014, 9'h010, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h018, 9'h014, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h01C, 9'h018, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h020, 9'h01C, 0, 9'h000, 0, 0));
    vecs.push_back(adv(9'h024, 9'h020, 0, 9'h000, 0, 0));
    vecs.push_back(mis(0, 9'h020, 1, 9'h010, 0, 9'h000, 9'h010, 1, 1));
    vecs.push_back(adv(9'h014, 9'h010, 0, 9'h010, 1, 1));
    vecs.push_back(adv(9'h018, 9'h014, 0, 9'h000, 1, 1));
    vecs.push_back(adv(9'h01C, 9'h018, 0, 9'h000, 1, 1));
    vecs.push_back(adv(9'h020, 9'h01C, 0, 9'h000, 1, 1));
    vecs.push_back(adv(9'h010, 9'h020, 1, 9'h010, 1, 1));
    vecs.push_back(v(0, 1, 1, 9'h020, 1, 9'h010, 1, 9'h010, 0, 9'h014, 1, 9'h010, 0, 9'h010, 2, 1));
    vecs.push_back(mis(0, 9'h020, 0, 9'h000, 1, 9'h010, 9'h024, 3, 2));
    vecs.push_back(mis(0, 9'h01C, 0, 9'h000, 1, 9'h000, 9'h020, 4, 3));
    vecs.push_back(adv(9'h010, 9'h020, 1, 9'h010, 4, 3));
    vecs.push_back(mis(0, 9'h020, 0, 9'h000, 1, 9'h010, 9'h024, 5, 4));
    vecs.push_back(mis(0, 9'h01C, 0, 9'h000, 1, 9'h000, 9'h020, 6, 5));
    vecs.push_back(adv(9'h024, 9'h020, 0, 9'h010, 6, 5));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(1, 0, 0, 9'h0, 0, 9'h0, 0, 9'h0, 0, 9'h024, 1, 9'h020, 0, 9'h010, 6, 5));
    vecs.push_back(mis(1, 9'h030, 1, 9'h040, 0, 9'h000, 9'h040, 7, 6));
    vecs.push_back(adv(9'h044, 9'h040, 0, 9'h040, 7, 6));
    vecs.push_back(mis(0, 9'h004, 1, 9'h080, 0, 9'h000, 9'h080, 8, 7));
    vecs.push_back(adv(9'h084, 9'h080, 0, 9'h040, 8, 7));
    vecs.push_back(mis(0, 9'h014, 1, 9'h0C0, 0, 9'h000, 9'h0C0, 9, 8));
    vecs.push_back(adv(9'h0C4, 9'h0C0, 0, 9'h040, 9, 8));
    vecs.push_back(adv(9'h0C8, 9'h0C4, 0, 9'h0C0, 9, 8));
    vecs.push_back(mis(0, 9'h000, 0, 9'h000, 1, 9'h000, 9'h004, 10, 9));
    vecs.push_back(adv(9'h008, 9'h004, 0, 9'h0C0, 10, 9));
    vecs.push_back(mis(0, 9'h010, 0, 9'h000, 1, 9'h000, 9'h014, 11, 10));
    vecs.push_back(adv(9'h0C0, 9'h014, 1, 9'h0C0, 11, 10));
    vecs.push_back(mis(0, 9'h1F8, 0, 9'h000, 1, 9'h000, 9'h1FC, 12, 11));
    vecs.push_back(adv(9'h000, 9'h1FC, 0, 9'h000, 12, 11));
    vecs.push_back(mis(0, 9'h030, 1, 9'h050, 1, 9'h040, 9'h050, 13, 12));
    vecs.push_back(adv(9'h054, 9'h050, 0, 9'h050, 13, 12));
    vecs.push_back(v(0, 1, 0, 9'h030, 1, 9'h050, 0, 9'h000, 0, 9'h058, 1, 9'h054, 0, 9'h0C0, 13, 12));
    vecs.push_back(v(0, 0, 1, 9'h030, 1, 9'h050, 0, 9'h000, 0, 9'h05C, 1, 9'h058, 0, 9'h000, 13, 12));
    vecs.push_back(v(0, 1, 1, 9'h030, 0, 9'h000, 0, 9'h099, 0, 9'h060, 1, 9'h05C, 0, 9'h000, 14, 12));

    #1;
    checkReset("reset");
    check("reset flush", flush, 1'b0);
    #2 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset in the middle of a cycle must clear state at once.
    #3 rst = 1'b1;
    #1;
    checkReset("midreset");
    #2 rst = 1'b0;

    // Cleared BTB: 0x14 no longer hits and the old branch mispredicts again.
    for (int k = 1; k <= 6; k++)
      applyStimulus(adv(PW'(4 * k), PW'(4 * (k - 1)), 0, 9'h000, 0, 0), $sformatf("post%0d", k));
    applyStimulus(mis(0, 9'h014, 1, 9'h0C0, 0, 9'h000, 9'h0C0, 1, 1), "post_mis");
    applyStimulus(adv(9'h0C4, 9'h0C0, 0, 9'h000, 1, 1), "post_adv");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/predicted_fetch_unit.md
# predicted_fetch_unit

Parametrised instruction-fetch front end that replaces the fixed PC+4 / branch-redirect fetch path of the 5-stage RISC-V core. It holds the PC register, drives the instruction-memory address, and predicts taken branches/jumps with a direct-mapped branch target buffer (BTB) plus 2-bit saturating counters. It registers the IF/ID buffer, tagged with the prediction. It accepts branch resolution from EX, issues the flush/redirect on a mispredict, and keeps performance counters.

## Interface
- PC_WIDTH, 9, PC/address width in bits
- INSTRUCTION_WIDTH, 32, instruction word width
- BTB_ENTRIES, 16, BTB entries; power of two, ≥2
- RESET_PC, 0, PC value after reset
- CNT_WIDTH, 16, width of each performance counter

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  hazard-unit load-use stall; holds PC and IF/ID
- imem_addr  out  PC_WIDTH  instruction-memory address (= pc)
- imem_data  in  INSTRUCTION_WIDTH  instruction at imem_addr, combinational read
- ex_valid  in  1  resolution bus valid (non-bubble instruction in EX)
- ex_is_branch  in  1  EX instruction is a branch or jump
- ex_pc  in  PC_WIDTH  PC of the EX instruction
- ex_taken  in  1  actual outcome
- ex_target  in  PC_WIDTH  actual target when taken
- ex_pred_taken  in  1  prediction carried down with the instruction
- ex_pred_target  in  PC_WIDTH  predicted target carried down
- if_valid  out  1  IF/ID holds a real instruction
- if_pc  out  PC_WIDTH  IF/ID PC
- if_instr  out  INSTRUCTION_WIDTH  IF/ID instruction
- if_pred_taken  out  1  IF/ID prediction
- if_pred_target  out  PC_WIDTH  IF/ID predicted target
- flush  out  1  combinational mispredict; squashes IF/ID and ID/EX
- branch_cnt  out  CNT_WIDTH  resolved branches
- mispred_cnt  out  CNT_WIDTH  mispredicts

## Operation
- IDX_W = log2(BTB_ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[PC_WIDTH-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Lookup (combinational on pc): hit = valid & tag match. pred_taken = hit & counter[1]. pred_target = entry target. next_pc = pred_taken ? pred_target : pc+4. Arithmetic is modulo 2^PC_WIDTH, so the PC wraps.
- Mispredict = ex_valid & ex_is_branch & ((ex_taken ≠ ex_pred_taken) | (ex_taken & ex_target ≠ ex_pred_target)). flush = mispredict. Redirect = ex_taken ? ex_target : ex_pc+4.
- BTB update on ex_valid & ex_is_branch:
  - Entry hit: counter increments on taken and decrements on not-taken, saturating at 3 and 0. On taken, the target is rewritten.
  - Entry miss and taken: allocate valid=1, tag, target, counter=2'b10 (replaces any occupant).
  - Entry miss and not-taken: no change.
- PC / IF/ID priority: rst > flush > stall > advance.
  - Flush: pc ← redirect; if_valid ← 0; IF/ID instruction and PC are zeroed.
  - Stall (no flush): pc and all IF/ID outputs hold.
  - Advance: pc ← next_pc; IF/ID ← {1, pc, imem_data, pred_taken, pred_target}.
- Counters increment on every update event (branch_cnt) and every mispredict (mispred_cnt). They wrap, and are independent of stall.

## Timing
- Reset, async on rst rising: pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, if_pred_*=0, all BTB valid=0, all BTB counters=2'b01, branch_cnt=0, mispred_cnt=0.
- Fetch latency is 1 cycle: the instruction at pc appears on if_* after the next clk edge.
- flush is asserted in the same cycle the branch is in EX. The redirected instruction is in IF/ID 2 edges later, giving a 2-cycle mispredict penalty. A correct prediction has 0 penalty.
- BTB writes occur at the clk edge. A same-cycle lookup of the index being updated sees the pre-update contents.
- flush and stall together: flush wins and the stall is dropped.
- rst asserted mid-operation clears everything immediately, including in-flight predictions. The first fetch after deassertion is at RESET_PC.

## Structure
- The shared pipeline buffer-register package gains:
  - a BTB-entry struct (valid, tag, target, counter);
  - a branch-resolution struct (the ex_* fields);
  - IF/ID fields for pred_taken and pred_target.
- Sub-module btb_table holds the entry array, combinational lookup, registered update logic and the async clear. The top level holds the PC, IF/ID, mispredict logic and counters.

## Test plan
- Reset with RESET_PC=0, rst released, no branches -> imem_addr 0,4,8,12…; if_valid=0 in cycle 0, then 1; if_pc lags by one cycle.
- Loop branch at 0x20 to 0x10, resolved taken on first encounter -> flush=1, pc←0x10, mispred_cnt=1. Second encounter predicts taken with target 0x10 and flush=0; branch_cnt=2.
- Entry trained to counter=3, then resolved not-taken twice -> first not-taken flushes and redirects to 0x24 (counter→2). The next lookup still predicts taken. After the second not-taken (counter→1) the prediction is not-taken.
- stall held 3 cycles -> pc and if_* unchanged. stall with simultaneous mispredict -> flush wins, pc=redirect, if_valid=0.
- Aliasing with BTB_ENTRIES=4: taken branches at 0x04 and 0x14 share an index -> the second allocation evicts the first. 0x04 then misses and predicts pc+4.
- PC at 2^PC_WIDTH−4 with no branch -> next pc wraps to 0. rst pulsed mid-loop -> BTB cleared and the same branch mispredicts again.
